// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx: aligns a 1-bit line stream on the comma character,
// then presents aligned bytes with a payload-valid flag and a boundary strobe.
// Optional feature macro: SP_SYNC_LOSS_EN (drop back to HUNT after LOSS_BYTES
// consecutive aligned bytes that are neither comma nor idle).
//
// state  | meaning
// HUNT   | scanning every bit position for a comma
// ALIGN  | comma seen, counting further aligned commas
// ACTIVE | link up, emitting one byte per 8-bit boundary
module serial_to_parallel_rx #(
  parameter logic [7:0]  BC_BYTE    = 8'hBC,
  parameter logic [7:0]  IDLE_BYTE  = 8'h7C,
  parameter int unsigned BC_COUNT   = 4,
  parameter int unsigned LOSS_BYTES = 16
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active_out
);

  typedef enum logic [1:0] {HUNT, ALIGN, ACTIVE} state_t;

  localparam logic [3:0] BC_COUNT_L = BC_COUNT[3:0];

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;
  logic       active_q, active_d;
  logic [7:0] nxt;
  logic [3:0] bc_inc;
  logic       boundary;
  logic       is_ctrl;

`ifdef SP_SYNC_LOSS_EN
  localparam logic [7:0] LOSS_L = LOSS_BYTES[7:0];
  logic [7:0] run_q, run_d;
  logic [7:0] run_inc;
`else
  logic [7:0] unused_loss;
  assign unused_loss = LOSS_BYTES[7:0];
`endif

  // Next-state logic: shift, alignment tracking and byte presentation
  always_comb begin
    nxt       = {sr_q[6:0], data_in};
    sr_d      = nxt;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;
    bc_inc    = bc_cnt_q + 4'd1;
    boundary  = (bit_cnt_q == 3'd7);
    is_ctrl   = (nxt == BC_BYTE) || (nxt == IDLE_BYTE);
`ifdef SP_SYNC_LOSS_EN
    run_d     = run_q;
    run_inc   = run_q + 8'd1;
`endif
    case (state_q)
      HUNT: begin
        valid_d = 1'b0;
        if (nxt == BC_BYTE) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd1;
          state_d   = (BC_COUNT_L == 4'd1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        valid_d   = 1'b0;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (nxt == BC_BYTE) begin
            bc_cnt_d = bc_inc;
            if (bc_inc == BC_COUNT_L) state_d = ACTIVE;
          end else begin
            bc_cnt_d = 4'd0;
            state_d  = HUNT;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          data_d   = nxt;
          strobe_d = 1'b1;
          valid_d  = !is_ctrl;
`ifdef SP_SYNC_LOSS_EN
          // The byte that trips the loss count is still delivered as payload.
          if (is_ctrl) begin
            run_d = 8'd0;
          end else if (run_inc == LOSS_L) begin
            run_d    = 8'd0;
            bc_cnt_d = 4'd0;
            state_d  = HUNT;
          end else begin
            run_d = run_inc;
          end
`endif
        end
      end
      default: state_d = HUNT;
    endcase
    active_d = (state_d == ACTIVE);
  end

  // State and output registers, cleared asynchronously while reset is low
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q   <= HUNT;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
`ifdef SP_SYNC_LOSS_EN
      run_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      active_q  <= active_d;
`ifdef SP_SYNC_LOSS_EN
      run_q     <= run_d;
`endif
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active_out  = active_q;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Bench for serial_to_parallel_rx: random and directed bit streams compared
// every cycle against a stream-level reference model.
module tb_serial_to_parallel_rx;

  localparam logic [7:0] BC   = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;
  localparam int NCOMMA = 4;
  localparam int NLOSS  = 16;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out, byte_strobe, active_out;

  int checks = 0;
  int errors = 0;

  // reference model: mode 0 hunting, 1 counting commas, 2 link up
  int         m_mode, m_since, m_commas, m_run;
  logic [7:0] m_hist, m_data;
  logic       m_valid, m_strobe;
  logic       bits_q[$];

  serial_to_parallel_rx #(
    .BC_BYTE(BC), .IDLE_BYTE(IDLE), .BC_COUNT(NCOMMA), .LOSS_BYTES(NLOSS)
  ) dut (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out),
    .byte_strobe(byte_strobe), .active_out(active_out)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic model_reset();
    m_mode = 0; m_since = 0; m_commas = 0; m_run = 0;
    m_hist = 8'h00; m_data = 8'h00; m_valid = 1'b0; m_strobe = 1'b0;
  endtask

  // the last 8 bits received form the candidate byte; boundaries fall every
  // 8th bit counted from the bit that completed the first comma
  task automatic model_step(input logic b);
    logic [7:0] n;
    logic bnd;
    n = {m_hist[6:0], b};
    m_hist = n;
    m_strobe = 1'b0;
    if (m_mode == 0) begin
      m_valid = 1'b0;
      if (n == BC) begin
        m_since = 0; m_commas = 1;
        m_mode = (NCOMMA == 1) ? 2 : 1;
      end
    end else begin
      m_since++;
      bnd = (m_since % 8 == 0);
      if (m_mode == 1) begin
        m_valid = 1'b0;
        if (bnd) begin
          if (n == BC) begin
            m_commas++;
            if (m_commas == NCOMMA) m_mode = 2;
          end else m_mode = 0;
        end
      end else if (bnd) begin
        m_data = n; m_strobe = 1'b1;
        m_valid = (n != BC) && (n != IDLE);
`ifdef SP_SYNC_LOSS_EN
        if (!m_valid) m_run = 0;
        else begin
          m_run++;
          if (m_run == NLOSS) begin m_run = 0; m_mode = 0; end
        end
`endif
      end
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    model_step(b);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) bits_q.push_back(v[i]);
  endtask

  task automatic pulse_reset();
    @(negedge clk_32f);
    reset = 1'b0;
    model_reset();
    @(negedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic b;
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_32f);
    #1;
    checks++;
    if ({data_out, valid_out, byte_strobe, active_out} !== 11'h0) begin
      errors++;
      $display("FAIL reset_init: got %h/%b/%b/%b want 00/0/0/0", data_out, valid_out, byte_strobe, active_out);
    end
    @(negedge clk_32f);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b = 1'($urandom_range(0, 1));
      drive_bit(b);
      checks++;
      if ({data_out, valid_out, byte_strobe, active_out} !== {m_data, m_valid, m_strobe, (m_mode == 2)}) begin
        errors++;
        $display("FAIL reset_stream bit %0d: got %h/%b/%b/%b want %h/%b/%b/%b", i, data_out, valid_out, byte_strobe, active_out, m_data, m_valid, m_strobe, (m_mode == 2));
      end
    end
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({data_out, valid_out, byte_strobe, active_out} !== 11'h0) begin
      errors++;
      $display("FAIL reset_mid: got %h/%b/%b/%b want 00/0/0/0", data_out, valid_out, byte_strobe, active_out);
    end
    @(negedge clk_32f);
    reset = 1'b1;
  endtask

  task automatic test_align();
    int rise_at;
    bits_q.delete();
    for (int i = 0; i < 3; i++) bits_q.push_back(1'($urandom_range(0, 1)));
    repeat (NCOMMA) push_byte(BC);
    push_byte(IDLE);
    rise_at = -1;
    for (int i = 0; i < bits_q.size(); i++) begin
      drive_bit(bits_q[i]);
      if (active_out === 1'b1 && rise_at < 0) rise_at = i - 2;
      checks++;
      if ({data_out, valid_out, byte_strobe, active_out} !== {m_data, m_valid, m_strobe, (m_mode == 2)}) begin
        errors++;
        $display("FAIL align bit %0d: got %h/%b/%b/%b want %h/%b/%b/%b", i, data_out, valid_out, byte_strobe, active_out, m_data, m_valid, m_strobe, (m_mode == 2));
      end
    end
    checks++;
    if (rise_at != 8 * NCOMMA) begin
      errors++;
      $display("FAIL align_latency: active rose at comma bit %0d want %0d", rise_at, 8 * NCOMMA);
    end
    checks++;
    if ({data_out, valid_out, byte_strobe} !== {IDLE, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL align_idle: got %h/%b/%b want 7c/0/1", data_out, valid_out, byte_strobe);
    end
  endtask

  task automatic test_payload();
    logic [7:0] exp_b[4];
    logic       exp_v[4];
    exp_b = '{8'hBC, 8'h55, 8'hAA, 8'h7C};
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      for (int i = 7; i >= 0; i--) begin
        drive_bit(exp_b[k][i]);
        checks++;
        if ({data_out, valid_out, byte_strobe, active_out} !== {m_data, m_valid, m_strobe, (m_mode == 2)}) begin
          errors++;
          $display("FAIL payload byte %0d bit %0d: got %h/%b/%b/%b want %h/%b/%b/%b", k, i, data_out, valid_out, byte_strobe, active_out, m_data, m_valid, m_strobe, (m_mode == 2));
        end
      end
      checks++;
      if ({data_out, valid_out, byte_strobe} !== {exp_b[k], exp_v[k], 1'b1}) begin
        errors++;
        $display("FAIL payload_strobe %0d: got %h/%b/%b want %h/%b/1", k, data_out, valid_out, byte_strobe, exp_b[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_reset_realign();
    logic [7:0] pay;
    pay = 8'h5A;
    for (int i = 7; i >= 5; i--) drive_bit(pay[i]);
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({data_out, valid_out, byte_strobe, active_out} !== 11'h0) begin
      errors++;
      $display("FAIL realign_async: got %h/%b/%b/%b want 00/0/0/0", data_out, valid_out, byte_strobe, active_out);
    end
    @(negedge clk_32f);
    reset = 1'b1;
    bits_q.delete();
    repeat (NCOMMA) push_byte(BC);
    for (int i = 0; i < bits_q.size(); i++) begin
      drive_bit(bits_q[i]);
      checks++;
      if ({data_out, valid_out, byte_strobe, active_out} !== {m_data, m_valid, m_strobe, (m_mode == 2)}) begin
        errors++;
        $display("FAIL realign bit %0d: got %h/%b/%b/%b want %h/%b/%b/%b", i, data_out, valid_out, byte_strobe, active_out, m_data, m_valid, m_strobe, (m_mode == 2));
      end
      if (i == 8 * NCOMMA - 2) begin
        checks++;
        if (active_out !== 1'b0) begin
          errors++;
          $display("FAIL realign_early: active %b want 0", active_out);
        end
      end
    end
    checks++;
    if (active_out !== 1'b1) begin
      errors++;
      $display("FAIL realign_up: active %b want 1", active_out);
    end
  endtask

  task automatic test_random_stream();
    logic [7:0] v;
    int sel;
    bits_q.delete();
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      v = (sel == 0) ? BC : (sel == 1) ? IDLE : 8'($urandom);
      push_byte(v);
      if (k == 20) for (int j = 0; j < 3; j++) bits_q.push_back(1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < bits_q.size(); i++) begin
      drive_bit(bits_q[i]);
      checks++;
      if ({data_out, valid_out, byte_strobe, active_out} !== {m_data, m_valid, m_strobe, (m_mode == 2)}) begin
        errors++;
        $display("FAIL random bit %0d: got %h/%b/%b/%b want %h/%b/%b/%b", i, data_out, valid_out, byte_strobe, active_out, m_data, m_valid, m_strobe, (m_mode == 2));
      end
    end
  endtask

  task automatic test_abort();
    pulse_reset();
    bits_q.delete();
    push_byte(BC); push_byte(BC); push_byte(8'h00);
    repeat (NCOMMA) push_byte(BC);
    for (int i = 0; i < bits_q.size(); i++) begin
      drive_bit(bits_q[i]);
      checks++;
      if ({data_out, valid_out, byte_strobe, active_out} !== {m_data, m_valid, m_strobe, (m_mode == 2)}) begin
        errors++;
        $display("FAIL abort bit %0d: got %h/%b/%b/%b want %h/%b/%b/%b", i, data_out, valid_out, byte_strobe, active_out, m_data, m_valid, m_strobe, (m_mode == 2));
      end
      if (i == bits_q.size() - 2) begin
        checks++;
        if (active_out !== 1'b0) begin
          errors++;
          $display("FAIL abort_early: active %b want 0", active_out);
        end
      end
    end
    checks++;
    if (active_out !== 1'b1) begin
      errors++;
      $display("FAIL abort_up: active %b want 1", active_out);
    end
  endtask

`ifdef SP_SYNC_LOSS_EN
  task automatic test_sync_loss();
    int strobes;
    pulse_reset();
    bits_q.delete();
    repeat (NCOMMA) push_byte(BC);
    repeat (NLOSS + 3) push_byte(8'h11);
    strobes = 0;
    for (int i = 0; i < bits_q.size(); i++) begin
      drive_bit(bits_q[i]);
      if (byte_strobe === 1'b1) strobes++;
      checks++;
      if ({data_out, valid_out, byte_strobe, active_out} !== {m_data, m_valid, m_strobe, (m_mode == 2)}) begin
        errors++;
        $display("FAIL loss bit %0d: got %h/%b/%b/%b want %h/%b/%b/%b", i, data_out, valid_out, byte_strobe, active_out, m_data, m_valid, m_strobe, (m_mode == 2));
      end
      if (i == 8 * (NCOMMA + NLOSS) - 1) begin
        checks++;
        if ({data_out, valid_out, byte_strobe, active_out} !== {8'h11, 1'b1, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL loss_edge: got %h/%b/%b/%b want 11/1/1/0", data_out, valid_out, byte_strobe, active_out);
        end
      end
    end
    checks++;
    if (strobes != NLOSS) begin
      errors++;
      $display("FAIL loss_strobes: got %0d want %0d", strobes, NLOSS);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_align();
    test_payload();
    test_reset_realign();
    test_random_stream();
    test_abort();
`ifdef SP_SYNC_LOSS_EN
    test_sync_loss();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_rx.md
# serial_to_parallel_rx

Receive-side serial-to-parallel converter in the RX data path, directly upstream of the level-2 byte demux. It takes the 1-bit line stream at the 32f rate, aligns byte boundaries on the BC comma character, and presents aligned bytes with a valid flag and a boundary strobe. It reports link-up through `active_out`. IDLE and comma bytes are marked not-valid so the demux only receives payload.

## Interface
Parameters:
- `BC_BYTE`, 8'hBC, comma/alignment character
- `IDLE_BYTE`, 8'h7C, idle filler character
- `BC_COUNT`, 4, consecutive aligned commas required to declare link active (range 1..15)
- `LOSS_BYTES`, 16, consecutive aligned bytes without comma/idle that drop sync (SP_SYNC_LOSS_EN only; range 2..255)

Ports:
- `clk_32f`  in  1  bit clock, rising edge
- `reset`  in  1  asynchronous, active-low; state and outputs clear while low
- `data_in`  in  1  serial line bit, MSB of each byte first
- `data_out`  out  8  last aligned byte; held between boundaries
- `valid_out`  out  1  `data_out` is payload (not BC, not IDLE) and link active; held with `data_out`
- `byte_strobe`  out  1  one-cycle pulse on the edge that loads `data_out`
- `active_out`  out  1  alignment achieved, level

## Operation
- Shift register `sr`: every edge `sr <= {sr[6:0], data_in}`; `nxt` = `{sr[6:0], data_in}`.
- 3-bit `bit_cnt`, 4-bit `bc_cnt`. FSM states:
  - HUNT (reset state): `bit_cnt` ignored. On each edge where `nxt == BC_BYTE`: `bit_cnt <= 0`, `bc_cnt <= 1`, go ALIGN; if `BC_COUNT == 1`, go ACTIVE directly.
  - ALIGN: `bit_cnt` increments and wraps 7->0. A boundary is an edge where `bit_cnt == 7`. At each boundary:
    - `nxt == BC_BYTE`: `bc_cnt++`; on reaching `BC_COUNT`, go ACTIVE.
    - otherwise: `bc_cnt <= 0` and return to HUNT. The same edge does not re-check `nxt`.
  - ACTIVE: `active_out = 1`. At each boundary:
    - `data_out <= nxt`
    - `byte_strobe <= 1`
    - `valid_out <= (nxt != BC_BYTE) && (nxt != IDLE_BYTE)`
    - Remains ACTIVE until reset, or sync loss if configured.
- `data_out`, `valid_out` and `byte_strobe` update only in ACTIVE. In HUNT/ALIGN: `valid_out = 0`, `byte_strobe = 0`, `data_out` holds its last value (0 after reset).
- Comma appearing misaligned while ACTIVE: treated as ordinary data bits; no realignment.
- Reset mid-byte: all state clears immediately and asynchronously. Alignment restarts from HUNT after `reset` rises; partial bits are discarded.
- Reset values: `data_out = 8'h00`, `valid_out = 0`, `byte_strobe = 0`, `active_out = 0`, `sr = 0`, `bit_cnt = 0`, `bc_cnt = 0`, state HUNT.

## Timing
- Latency: last bit (LSB) of a byte is sampled at edge k; `data_out`, `valid_out` and `byte_strobe` are visible after edge k. `byte_strobe` falls after edge k+1.
- In ACTIVE, boundaries are exactly 8 cycles apart. Downstream samples `data_out` on `byte_strobe`, or with a clock divided by 8 phase-locked to the strobe.
- `active_out` rises after the edge completing the `BC_COUNT`-th aligned comma. The first strobe follows 8 cycles later.
- Minimum time from reset release to `active_out`: 8·`BC_COUNT` cycles. That is 32 cycles with defaults (first comma completes at edge 8).

## Configuration
- `SP_SYNC_LOSS_EN` defined:
  - An 8-bit run counter in ACTIVE clears at any boundary byte equal to `BC_BYTE` or `IDLE_BYTE`, and increments otherwise.
  - When it reaches `LOSS_BYTES`, the FSM returns to HUNT on that boundary edge.
  - That byte is still output with `valid_out = 1`. `active_out` falls after the same edge; `valid_out` clears on the next edge.
- Not defined: no run counter; ACTIVE is exited only by reset.

## Test plan
- Reset low mid-stream, then release: all outputs 0 and `active_out = 0` within the reset-low interval; no strobe until realigned.
- 3 bits of junk, then 4×8'hBC: `active_out` rises after the 4th comma's LSB; then 8'h7C gives a strobe with `valid_out = 0`, `data_out = 8'h7C`.
- After active, 8'hBC, 8'h55, 8'hAA, 8'h7C: strobes every 8 cycles with `data_out` 8'hBC/0, 8'h55/1, 8'hAA/1, 8'h7C/0 (shown as byte/`valid_out`).
- 2×8'hBC, then 8'h00, then 4×8'hBC: ALIGN aborts on 8'h00 and returns to HUNT; `active_out` rises only after the later 4 commas.
- Assert `reset` 3 bits into a payload byte while ACTIVE: `active_out`, `valid_out` and `data_out` go 0 asynchronously; realignment requires 4 fresh commas.
- `SP_SYNC_LOSS_EN`, active link, then 16 bytes of 8'h11: 16 valid strobes; `active_out` falls after the 16th strobe edge; no further strobes.
